// File: rtl/depthwise_seq_ctrl_if.sv
// Operand, array and result signals between the depthwise sequencer and its surroundings.
// slave is the controller's view; master is the view of whatever drives it.
interface depthwise_seq_ctrl_if #(
    parameter int NUM_PE         = 16,
    parameter int DATA_WIDTH     = 8,
    parameter int OUT_DATA_WIDTH = 32,
    parameter int TAP_W          = 4
);
    logic                             start;
    logic [TAP_W-1:0]                 num_taps;
    logic                             busy;
    logic                             done;
    logic                             err;
    logic                             in_valid;
    logic                             in_ready;
    logic [NUM_PE*DATA_WIDTH-1:0]     kernel_in;
    logic [NUM_PE*DATA_WIDTH-1:0]     act_in;
    logic [NUM_PE*DATA_WIDTH-1:0]     kernel_out;
    logic [NUM_PE*DATA_WIDTH-1:0]     act_out;
    logic                             first_data;
    logic [NUM_PE*OUT_DATA_WIDTH-1:0] result_in;
    logic                             res_valid;
    logic                             res_ready;
    logic [NUM_PE*OUT_DATA_WIDTH-1:0] res_data;

    modport slave (
        input  start, num_taps, in_valid, kernel_in, act_in, result_in, res_ready,
        output busy, done, err, in_ready, kernel_out, act_out, first_data, res_valid, res_data
    );

    modport master (
        output start, num_taps, in_valid, kernel_in, act_in, result_in, res_ready,
        input  busy, done, err, in_ready, kernel_out, act_out, first_data, res_valid, res_data
    );
endinterface

// File: rtl/depthwise_seq_ctrl.sv
// Window sequencer for the 16-lane depthwise SIMD PE array: feeds operand beats,
// waits for the PE pipeline to drain, then holds the lane sums on a valid/ready port.
//
// state | meaning
// IDLE  | waiting for start
// FEED  | accepting operand beats, driving the array
// DRAIN | operands zeroed, counting down PE_LAT before capturing result_in
// HOLD  | res_data presented, waiting for res_ready
module depthwise_seq_ctrl #(
    parameter int NUM_PE         = 16,
    parameter int DATA_WIDTH     = 8,
    parameter int OUT_DATA_WIDTH = 32,
    parameter int TAP_W          = 4,
    parameter int PE_LAT         = 1
) (
    input logic                 clk,
    input logic                 reset,
    depthwise_seq_ctrl_if.slave bus
);
    localparam int VW    = NUM_PE * DATA_WIDTH;
    localparam int RW    = NUM_PE * OUT_DATA_WIDTH;
    localparam int LAT_W = (PE_LAT < 2) ? 1 : $clog2(PE_LAT + 1);

    typedef enum logic [1:0] {IDLE, FEED, DRAIN, HOLD} state_t;

    state_t            state, state_nxt;
    logic [TAP_W-1:0]  taps_q, tap_cnt;
    logic [LAT_W-1:0]  lat_cnt;
    logic [VW-1:0]     kernel_q, act_q;
    logic [RW-1:0]     res_q;
    logic              first_q, done_q, err_q;
    logic              beat, last_beat;

    assign beat      = (state == FEED) && bus.in_valid;
    assign last_beat = beat && (tap_cnt == taps_q - TAP_W'(1));

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start && (bus.num_taps != '0)) state_nxt = FEED;
            FEED:    if (last_beat)                          state_nxt = DRAIN;
            DRAIN:   if (lat_cnt == '0)                      state_nxt = HOLD;
            HOLD:    if (bus.res_ready)                      state_nxt = IDLE;
            default:                                         state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            taps_q   <= '0;
            tap_cnt  <= '0;
            lat_cnt  <= '0;
            kernel_q <= '0;
            act_q    <= '0;
            first_q  <= 1'b0;
            res_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            err_q  <= (state == IDLE) && bus.start && (bus.num_taps == '0);
            done_q <= (state == HOLD) && bus.res_ready;
            // Bubbles drive zero operands so the PE accumulates a zero product.
            kernel_q <= beat ? bus.kernel_in : '0;
            act_q    <= beat ? bus.act_in    : '0;
            first_q  <= beat && (tap_cnt == '0);

            if ((state == IDLE) && bus.start) begin
                taps_q  <= bus.num_taps;
                tap_cnt <= '0;
            end else if (beat) begin
                tap_cnt <= tap_cnt + TAP_W'(1);
            end

            if (last_beat)
                lat_cnt <= LAT_W'(PE_LAT);
            else if ((state == DRAIN) && (lat_cnt != '0))
                lat_cnt <= lat_cnt - LAT_W'(1);

            if ((state == DRAIN) && (lat_cnt == '0))
                res_q <= bus.result_in;
        end
    end

    assign bus.busy       = (state != IDLE);
    assign bus.in_ready   = (state == FEED);
    assign bus.res_valid  = (state == HOLD);
    assign bus.res_data   = res_q;
    assign bus.kernel_out = kernel_q;
    assign bus.act_out    = act_q;
    assign bus.first_data = first_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_depthwise_seq_ctrl.sv
// Bench for depthwise_seq_ctrl: behavioural PE array, directed windows, and a result
// scoreboard popped by a monitor on every res_valid/res_ready handshake.
module tb_depthwise_seq_ctrl;
    localparam int NUM_PE = 16;
    localparam int DW     = 8;
    localparam int OW     = 32;
    localparam int TAP_W  = 4;
    localparam int PE_LAT = 1;
    localparam int KW     = NUM_PE * DW;
    localparam int RW     = NUM_PE * OW;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   tests = 0;
    int   fails = 0;
    logic [RW-1:0] exp_q [$];

    always #5 clk = ~clk;

    depthwise_seq_ctrl_if #(.NUM_PE(NUM_PE), .DATA_WIDTH(DW), .OUT_DATA_WIDTH(OW), .TAP_W(TAP_W)) bus ();

    depthwise_seq_ctrl #(
        .NUM_PE(NUM_PE), .DATA_WIDTH(DW), .OUT_DATA_WIDTH(OW), .TAP_W(TAP_W), .PE_LAT(PE_LAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic signed [OW-1:0] prod(input logic [DW-1:0] k, input logic [DW-1:0] a);
        logic signed [OW-1:0] ks, as_;
        ks  = {{(OW-DW){k[DW-1]}}, k};
        as_ = {{(OW-DW){a[DW-1]}}, a};
        return ks * as_;
    endfunction

    // Behavioural PE array with a one-cycle accumulate (PE_LAT = 1).
    logic signed [OW-1:0] acc [NUM_PE];
    always @(posedge clk) begin
        for (int i = 0; i < NUM_PE; i++) begin
            if (!reset)              acc[i] <= '0;
            else if (bus.first_data) acc[i] <= prod(bus.kernel_out[i*DW +: DW], bus.act_out[i*DW +: DW]);
            else                     acc[i] <= acc[i] + prod(bus.kernel_out[i*DW +: DW], bus.act_out[i*DW +: DW]);
        end
    end
    always_comb begin
        bus.result_in = '0;
        for (int i = 0; i < NUM_PE; i++) bus.result_in[i*OW +: OW] = acc[i];
    end

    task automatic check(input string name, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset && bus.res_valid && bus.res_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_result: got %0h expected none", bus.res_data);
            end else begin
                check("res_data", bus.res_data, exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [KW-1:0] splat(input logic [DW-1:0] v);
        logic [KW-1:0] r;
        for (int i = 0; i < NUM_PE; i++) r[i*DW +: DW] = v;
        return r;
    endfunction

    task automatic run_window(input string tag, input logic [KW-1:0] k, input logic [KW-1:0] a,
                              input int n, input int bub_after, input int bub_len, input int hold);
        logic [RW-1:0] exp;
        int lat, guard, bubbles;
        for (int i = 0; i < NUM_PE; i++) exp[i*OW +: OW] = prod(k[i*DW +: DW], a[i*DW +: DW]) * n;
        exp_q.push_back(exp);
        bubbles = 0;
        bus.start = 1'b1;
        bus.num_taps = TAP_W'(n);
        step();
        lat = 0;
        bus.start = 1'b0;
        bus.num_taps = '0;
        check({tag, "_busy"}, RW'(bus.busy), RW'(1));
        check({tag, "_in_ready"}, RW'(bus.in_ready), RW'(1));
        for (int b = 0; b < n; b++) begin
            bus.in_valid  = 1'b1;
            bus.kernel_in = k;
            bus.act_in    = a;
            step();
            lat++;
            check({tag, "_kernel_out"}, RW'(bus.kernel_out), RW'(k));
            check({tag, "_act_out"}, RW'(bus.act_out), RW'(a));
            check({tag, "_first_data"}, RW'(bus.first_data), RW'(b == 0));
            if (b == bub_after) begin
                for (int j = 0; j < bub_len; j++) begin
                    bus.in_valid  = 1'b0;
                    bus.kernel_in = '1;
                    bus.act_in    = '1;
                    step();
                    lat++;
                    bubbles++;
                    check({tag, "_bubble_kernel"}, RW'(bus.kernel_out), '0);
                    check({tag, "_bubble_act"}, RW'(bus.act_out), '0);
                    check({tag, "_bubble_first"}, RW'(bus.first_data), '0);
                end
            end
        end
        bus.in_valid  = 1'b0;
        bus.kernel_in = '1;
        guard = 0;
        while (!bus.res_valid && guard < 40) begin
            step();
            lat++;
            guard++;
        end
        check({tag, "_latency"}, RW'(lat), RW'(n + bubbles + 1 + PE_LAT));
        check({tag, "_done_early"}, RW'(bus.done), '0);
        for (int h = 0; h < hold; h++) begin
            bus.start = 1'b1;
            bus.num_taps = 4'd9;
            step();
            check({tag, "_hold_valid"}, RW'(bus.res_valid), RW'(1));
            check({tag, "_hold_data"}, bus.res_data, exp);
            check({tag, "_hold_in_ready"}, RW'(bus.in_ready), '0);
            check({tag, "_hold_done"}, RW'(bus.done), '0);
        end
        bus.start = 1'b0;
        bus.num_taps = '0;
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
        check({tag, "_done"}, RW'(bus.done), RW'(1));
        check({tag, "_valid_clr"}, RW'(bus.res_valid), '0);
        check({tag, "_idle"}, RW'(bus.busy), '0);
        step();
        check({tag, "_done_pulse"}, RW'(bus.done), '0);
    endtask

    initial begin
        logic [KW-1:0] kidx;
        bus.start = 1'b0;
        bus.num_taps = '0;
        bus.in_valid = 1'b0;
        bus.kernel_in = '0;
        bus.act_in = '0;
        bus.res_ready = 1'b0;
        reset = 1'b0;
        step();
        step();
        check("reset_busy", RW'(bus.busy), '0);
        check("reset_res_valid", RW'(bus.res_valid), '0);
        check("reset_res_data", bus.res_data, '0);
        reset = 1'b1;
        step();

        run_window("t1", splat(8'd2), splat(8'd3), 9, -1, 0, 0);
        run_window("t2", splat(8'd2), splat(8'd3), 9, 4, 3, 0);
        run_window("t3", splat(8'd2), splat(8'd3), 9, -1, 0, 10);

        bus.start = 1'b1;
        bus.num_taps = '0;
        step();
        bus.start = 1'b0;
        check("t4_err", RW'(bus.err), RW'(1));
        check("t4_busy", RW'(bus.busy), '0);
        check("t4_in_ready", RW'(bus.in_ready), '0);
        step();
        check("t4_err_pulse", RW'(bus.err), '0);
        check("t4_still_idle", RW'(bus.busy), '0);

        bus.start = 1'b1;
        bus.num_taps = 4'd9;
        step();
        bus.start = 1'b0;
        for (int b = 0; b < 5; b++) begin
            bus.in_valid = 1'b1;
            bus.kernel_in = splat(8'd2);
            bus.act_in = splat(8'd3);
            step();
        end
        reset = 1'b0;
        step();
        bus.in_valid = 1'b0;
        check("t5_busy", RW'(bus.busy), '0);
        check("t5_done", RW'(bus.done), '0);
        check("t5_err", RW'(bus.err), '0);
        check("t5_in_ready", RW'(bus.in_ready), '0);
        check("t5_first_data", RW'(bus.first_data), '0);
        check("t5_res_valid", RW'(bus.res_valid), '0);
        check("t5_kernel_out", RW'(bus.kernel_out), '0);
        check("t5_act_out", RW'(bus.act_out), '0);
        check("t5_res_data", bus.res_data, '0);
        reset = 1'b1;
        step();
        for (int i = 0; i < NUM_PE; i++) kidx[i*DW +: DW] = DW'(i);
        run_window("t5", kidx, splat(8'd1), 9, -1, 0, 0);

        run_window("t6a", splat(8'd1), splat(8'd1), 9, -1, 0, 0);
        run_window("t6b", splat(8'hFF), splat(8'd1), 9, -1, 0, 0);

        step();
        check("scoreboard_empty", RW'(exp_q.size()), '0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
